// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (s_in - a_in) mod 2^(N+1) one bit per
// cycle, LSB first, with a valid/ready handshake on both sides.
// The final difference and borrow are latched only when the last bit is
// processed, so d_out/borrow_out never show a partial result.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   s_in,
    input  logic [N-1:0] a_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   d_out,
    output logic         borrow_out,
    output logic         busy
);

    // Counter wide enough to hold index N without wrapping.
    localparam int              CW       = $clog2(N + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [N:0]    r_s;          // minuend shift register
    logic [N:0]    r_a;          // zero-extended subtrahend shift register
    logic          r_b;          // running borrow
    logic [CW-1:0] r_cnt;        // index of the bit being processed
    logic [N:0]    r_res;        // partial difference, filled from the MSB end
    logic [N:0]    r_d_out;      // last completed difference
    logic          r_borrow_out; // last completed borrow

    logic          w_s_bit;
    logic          w_a_bit;
    logic          w_diff_bit;
    logic          w_borrow_nxt;
    logic          w_last;

    assign w_s_bit      = r_s[0];
    assign w_a_bit      = r_a[0];
    assign w_diff_bit   = w_s_bit ^ w_a_bit ^ r_b;
    assign w_borrow_nxt = (~w_s_bit & w_a_bit) | (~w_s_bit & r_b) | (w_a_bit & r_b);
    assign w_last       = (r_cnt == LAST_BIT);

    assign d_out      = r_d_out;
    assign borrow_out = r_borrow_out;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, run N+1 bits, hold DONE until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake/status outputs decoded from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_RUN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands, shift one bit per RUN cycle, latch result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s          <= {(N+1){1'b0}};
            r_a          <= {(N+1){1'b0}};
            r_b          <= 1'b0;
            r_cnt        <= {CW{1'b0}};
            r_res        <= {(N+1){1'b0}};
            r_d_out      <= {(N+1){1'b0}};
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_s   <= s_in;
                        r_a   <= {1'b0, a_in};
                        r_b   <= 1'b0;
                        r_cnt <= {CW{1'b0}};
                        r_res <= {(N+1){1'b0}};
                    end
                end
                ST_RUN: begin
                    r_s   <= {1'b0, r_s[N:1]};
                    r_a   <= {1'b0, r_a[N:1]};
                    r_b   <= w_borrow_nxt;
                    r_res <= {w_diff_bit, r_res[N:1]};
                    // Hold the counter on the last bit so it can never wrap.
                    if (w_last) begin
                        r_d_out      <= {w_diff_bit, r_res[N:1]};
                        r_borrow_out <= w_borrow_nxt;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor with N=4.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   s_in;
    logic [N-1:0] a_in;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   d_out;
    logic         borrow_out;
    logic         busy;

    int           checks   = 0;
    int           failures = 0;
    logic [N:0]   last_d;

    serial_subtractor #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s_in       (s_in),
        .a_in       (a_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d_out      (d_out),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic [N:0] s, input logic [N-1:0] a);
        chk({tag, "_pre_in_ready"}, 32'(in_ready), 32'd1);
        s_in     = s;
        a_in     = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    // Waits for out_valid, checks latency, no partial results, and the result.
    task automatic wait_result(input string tag, input logic [N:0] exp_d, input logic exp_b);
        int   lat;
        logic partial;
        lat     = 0;
        partial = 1'b0;
        while (!out_valid && lat < 20) begin
            if (d_out !== last_d) partial = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
        chk({tag, "_no_partial"}, 32'(partial), 32'd0);
        chk({tag, "_d"}, 32'(d_out), 32'(exp_d));
        chk({tag, "_borrow"}, 32'(borrow_out), 32'(exp_b));
        last_d = exp_d;
    endtask

    // With out_ready high in DONE: one edge later the block is back in IDLE.
    task automatic handshake(input string tag, input logic [N:0] exp_d);
        @(negedge clk);
        chk({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hs_d_kept"}, 32'(d_out), 32'(exp_d));
    endtask

    task automatic run_op(input string tag, input logic [N:0] s, input logic [N-1:0] a,
                          input logic [N:0] exp_d, input logic exp_b);
        start_op(tag, s, a);
        wait_result(tag, exp_d, exp_b);
        handshake(tag, exp_d);
    endtask

    initial begin
        logic       seen_valid;
        logic       got;
        logic [N:0] sv;
        logic [N-1:0] av;
        logic [N:0] ed;
        logic       eb;
        int         t;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s_in      = '0;
        a_in      = '0;
        last_d    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Directed results, out_ready held high (also high during RUN)
        out_ready = 1'b1;
        run_op("s19_a7",  5'd19, 4'd7,  5'd12, 1'b0);
        run_op("s3_a9",   5'd3,  4'd9,  5'd26, 1'b1);
        run_op("s0_a15",  5'd0,  4'd15, 5'd17, 1'b1);
        run_op("s31_a15", 5'd31, 4'd15, 5'd16, 1'b0);
        run_op("s8_a8",   5'd8,  4'd8,  5'd0,  1'b0);
        run_op("s21_a0",  5'd21, 4'd0,  5'd21, 1'b0);

        // Backpressure with new operands waiting
        out_ready = 1'b0;
        start_op("bp", 5'd13, 4'd6);
        wait_result("bp", 5'd7, 1'b0);
        in_valid = 1'b1;
        s_in     = 5'd5;
        a_in     = 4'd2;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_d_stable", 32'(d_out), 32'd7);
            chk("bp_borrow_stable", 32'(borrow_out), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_out_valid", 32'(out_valid), 32'd0);
        chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
        chk("bp_hs_d_kept", 32'(d_out), 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_busy", 32'(busy), 32'd1);
        wait_result("bp_next", 5'd3, 1'b0);
        handshake("bp_next", 5'd3);

        // Reset during the second RUN cycle aborts the operation
        start_op("abort", 5'd9, 4'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_d_out", 32'(d_out), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        last_d     = '0;
        seen_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("abort_no_valid", 32'(seen_valid), 32'd0);
        run_op("after_rst", 5'd10, 4'd4, 5'd6, 1'b0);

        // Sweep every operand pair with random in_valid/out_ready
        for (int s = 0; s < 32; s++) begin
            for (int a = 0; a < 16; a++) begin
                sv = s[N:0];
                av = a[N-1:0];
                ed = sv - {1'b0, av};
                eb = (sv < {1'b0, av});
                in_valid  = 1'b0;
                out_ready = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                start_op("sweep", sv, av);
                got = 1'b0;
                t   = 0;
                while (t < 40) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    s_in      = 5'($urandom_range(0, 31));
                    a_in      = 4'($urandom_range(0, 15));
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid) begin
                        if (!got) begin
                            chk($sformatf("sweep_d_s%0d_a%0d", s, a), 32'(d_out), 32'(ed));
                            chk($sformatf("sweep_b_s%0d_a%0d", s, a), 32'(borrow_out), 32'(eb));
                            got = 1'b1;
                        end
                        if (out_ready) break;
                    end
                    @(negedge clk);
                    t++;
                end
                if (!got) chk($sformatf("sweep_timeout_s%0d_a%0d", s, a), 32'd0, 32'd1);
                @(negedge clk);
                in_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the width of operand A; the minuend and result are N+1 bits wide.
REQ-002 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operands on s_in/a_in are valid.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 s_in  in  N+1  minuend, an adder sum width, unsigned.
REQ-008 a_in  in  N  subtrahend, unsigned, zero-extended to N+1 internally.
REQ-009 out_valid  out  1  d_out/borrow_out hold a completed result.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 d_out  out  N+1  difference, (s_in - a_in) mod 2^(N+1).
REQ-012 borrow_out  out  1  1 iff s_in < a_in (unsigned).
REQ-013 busy  out  1  high in RUN or DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready=1; in every other state, in_ready=0.
REQ-016 Accept on a clk edge with in_valid&&in_ready:
  - capture s_in and a_in (zero-extended) into shift registers;
  - clear the borrow flop and the bit counter;
  - go to RUN.
REQ-017 In IDLE with in_valid=0, the FSM SHALL stay in IDLE; in_valid and operands SHALL be ignored outside IDLE.
REQ-018 RUN processes one bit per cycle, LSB first, with s, a and b = current bit and borrow:
  - difference bit = s^a^b;
  - next borrow = (~s&a)|(~s&b)|(a&b);
  - the difference bit shifts into the result register;
  - the counter increments.
REQ-019 RUN SHALL last exactly N+1 cycles; on the edge that processes bit N, the FSM SHALL go to DONE and latch the final borrow into borrow_out.
REQ-020 out_valid SHALL be 1 only in DONE, first asserted N+1 cycles after the accepting edge.
REQ-021 In DONE, d_out and borrow_out SHALL be stable until an edge with out_valid&&out_ready, which returns the FSM to IDLE.
REQ-022 out_ready SHALL have no effect while out_valid=0.
REQ-023 d_out and borrow_out SHALL retain the last completed result outside DONE and SHALL NOT show partial results.
REQ-024 No overlap:
  - the next operation is accepted no earlier than the cycle after the output handshake;
  - minimum period per operation is N+3 cycles with out_ready held high.
REQ-025 Boundary results:
  - s_in == a_in SHALL give d_out=0, borrow_out=0;
  - a_in=0 SHALL give d_out=s_in, borrow_out=0;
  - N=1 SHALL work (2-cycle RUN).
REQ-026 The bit counter SHALL be ceil(log2(N+1)) bits wide or wider and SHALL never wrap during RUN.

Reset
REQ-027 On a clk edge with rst=1, the block SHALL:
  - go to IDLE;
  - clear all shift registers, the counter and the borrow flop;
  - drive out_valid=0, d_out=0, borrow_out=0, busy=0 and in_ready=1 from the next cycle.
REQ-028 rst SHALL take priority over every handshake; reset during RUN or DONE SHALL abort the operation with no out_valid pulse.
REQ-029 After reset deassertion, the block SHALL accept operands on the first edge with in_valid=1.

Verification (N=4)
REQ-030 s_in=19, a_in=7, out_ready=1 -> out_valid rises 5 cycles after accept; d_out=12, borrow_out=0; in_ready returns 1 the next cycle.
REQ-031 s_in=3, a_in=9 -> d_out=26 (5'b11010), borrow_out=1; also s_in=0, a_in=15 -> d_out=17, borrow_out=1.
REQ-032 s_in=31, a_in=15 -> d_out=16, borrow_out=0; s_in=8, a_in=8 -> d_out=0, borrow_out=0.
REQ-033 Backpressure: out_ready=0 for 3 cycles after out_valid, with in_valid held high and new operands applied -> out_valid, d_out and borrow_out stay stable, in_ready=0, and the new operands are not accepted until after the output handshake.
REQ-034 rst pulsed 1 cycle on the 2nd RUN cycle -> no out_valid; in_ready=1 and outputs=0 the next cycle; a following s_in=10, a_in=4 gives d_out=6.
REQ-035 Random sweep over all 32x16 operand pairs with random in_valid/out_ready -> every result matches (s-a) mod 32 and the borrow matches s<a.
